regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Owns the single register-file write port (write-enable, 5-bit address, 32-bit data) and shares it between several write-back requesters, such as the ALU result, the load data and the debug/monitor path.
- After reset it runs a clear sequence that writes zero to all 32 registers.
- It then grants one requester per cycle, round-robin, over a valid/ready handshake.
- It drives registered write signals into the register file, and suppresses writes to x0.

Parameters:
NREQ, 3, number of write requesters (2..8)
XLEN, 32, data width
AW, 5, register address width (32 registers)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester write request
req_addr  in  NREQ*AW  packed destination addresses; requester i occupies bits [i*AW +: AW]
req_data  in  NREQ*XLEN  packed write data; requester i occupies bits [i*XLEN +: XLEN]
req_ready  out  NREQ  one-hot grant; a transfer occurs when valid and ready are both high
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  AW  register-file write address (registered)
rf_wdata  out  XLEN  register-file write data (registered)
init_done  out  1  high once the clear sequence has finished
grant_id  out  clog2(NREQ)  index of the last granted requester (registered)
x0_drop  out  1  one-cycle pulse: an accepted request targeted x0 and was discarded

Behaviour:
- Reset (async, rst_n=0):
  - state=CLEAR, clr_cnt=0, rr_ptr=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, init_done=0, grant_id=0, x0_drop=0.
  - req_ready=0.
- FSM has two states, CLEAR and RUN.
- CLEAR state:
  - Each cycle: rf_we<=1, rf_waddr<=clr_cnt, rf_wdata<=0, clr_cnt<=clr_cnt+1.
  - x0 is included in the sweep.
  - After the cycle that issues address 31, go to RUN and set init_done<=1. First clear write appears 1 cycle after reset release; the last is the 32nd.
  - req_ready is held at 0 for the whole state.
- RUN state, arbitration (combinational):
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - The first valid index g gets req_ready[g]=1; all other ready bits are 0.
  - If no requester is valid, all ready bits are 0.
- RUN state, on an accept (any valid&ready):
  - rr_ptr<=(g+1) mod NREQ and grant_id<=g.
  - rf_waddr<=req_addr[g] and rf_wdata<=req_data[g].
  - If req_addr[g]==0: rf_we<=0, x0_drop<=1. Otherwise: rf_we<=1, x0_drop<=0.
- RUN state, with no accept: rf_we<=0, x0_drop<=0. rf_waddr, rf_wdata, rr_ptr and grant_id hold their values.
- Latency: a request accepted in cycle t is written by the register file at the clock edge ending cycle t+1.
- Throughput: one write per cycle. A requester that keeps req_valid high is granted at least once every NREQ cycles, so no requester starves.
- Requester rules:
  - Once asserted, req_valid and its address/data must stay stable until accepted.
  - The arbiter does not buffer; a stalled requester simply waits.
- Reset mid-operation:
  - rst_n asserted during CLEAR or RUN immediately returns the block to the reset values.
  - Release restarts a full 32-cycle clear.
  - Any write in flight is lost; rf_we drops asynchronously.
- Width rules:
  - clr_cnt is AW+1 bits wide, so it can reach 32 without wrapping.
  - rr_ptr is clog2(NREQ) bits wide; wrap is by explicit compare to NREQ-1, not by overflow, because NREQ need not be a power of two.
- init_done stays 1 until the next reset.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN and AW constants, and NREGS=32;
  - the state enum (CLEAR, RUN);
  - an rf_wr_t struct {we, waddr, wdata}, which is also used by the register-file wrapper.
- One sub-module, rr_arbiter: a purely combinational round-robin priority picker. Inputs req[NREQ] and ptr; outputs one-hot gnt and index. The FSM and the output registers stay in regfile_wr_arbiter.

Test Plan:
- Reset release, no requests -> rf_we=1 for exactly 32 cycles with waddr 0..31 and wdata=0. init_done rises the cycle after waddr=31. req_ready stays 0 throughout.
- After init, req_valid=3'b001 with addr=5, data=32'hDEADBEEF -> req_ready=001 in cycle t. In cycle t+1: rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF, grant_id=0.
- All three requesters valid continuously (addrs 1/2/3) -> grants cycle 0,1,2,0,1,2. rf_waddr sequence 1,2,3,1,2,3 with rf_we held at 1.
- Requester 1 valid with addr=0, data=32'h1234 -> accepted (ready=010). Next cycle: rf_we=0, x0_drop=1 for one cycle, rr_ptr advances to 2.
- Assert rst_n=0 at clear cycle 10 for 1 cycle -> rf_we=0 and init_done=0 immediately. The clear restarts at waddr=0 and takes a full 32 cycles.
- rr_ptr=2 with only requester 0 valid -> grant wraps to 0. rr_ptr becomes 1. Requester 0 valid for 3 consecutive cycles is granted every cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file write-port types and constants.
package rf_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NREGS = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int unsigned cand;

  // Walk NREQ candidates from ptr; ptr is always < NREQ so one subtraction wraps.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[IW'(cand)]) begin
        any            = 1'b1;
        gnt[IW'(cand)] = 1'b1;
        idx            = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port owner: clears all registers after reset, then
// round-robin shares the port between write-back requesters, dropping x0 writes.
module regfile_wr_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 init_done,
  output logic [IW-1:0]        grant_id,
  output logic                 x0_drop
);

  localparam logic [AW:0]   CLR_END  = (AW+1)'(NREGS);
  localparam logic [IW-1:0] PTR_LAST = IW'(NREQ - 1);

  state_t          state, state_nxt;
  logic [AW:0]     clr_cnt, clr_cnt_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]   grant_q, grant_nxt;
  rf_wr_t          wr_q, wr_nxt;
  logic            init_q, init_nxt;
  logic            drop_q, drop_nxt;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gidx;
  logic            gany;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [XLEN-1:0] data_arr [NREQ];
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*AW +: AW];
    assign data_arr[i] = req_data[i*XLEN +: XLEN];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign sel_addr = addr_arr[gidx];
  assign sel_data = data_arr[gidx];

  // Next-state and next-output logic; write strobe and drop pulse default low.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    rr_ptr_nxt  = rr_ptr;
    grant_nxt   = grant_q;
    wr_nxt      = wr_q;
    wr_nxt.we   = 1'b0;
    init_nxt    = init_q;
    drop_nxt    = 1'b0;
    req_ready   = '0;
    case (state)
      CLEAR: begin
        // clr_cnt reaching 32 marks the cycle after the last clear write.
        if (clr_cnt == CLR_END) begin
          state_nxt = RUN;
          init_nxt  = 1'b1;
        end else begin
          wr_nxt.we    = 1'b1;
          wr_nxt.waddr = clr_cnt[AW-1:0];
          wr_nxt.wdata = '0;
          clr_cnt_nxt  = clr_cnt + 1'b1;
        end
      end
      RUN: begin
        req_ready = gnt;
        if (gany) begin
          wr_nxt.we    = |sel_addr;
          wr_nxt.waddr = sel_addr;
          wr_nxt.wdata = sel_data;
          drop_nxt     = ~|sel_addr;
          grant_nxt    = gidx;
          rr_ptr_nxt   = (gidx == PTR_LAST) ? '0 : gidx + 1'b1;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      rr_ptr  <= '0;
      grant_q <= '0;
      wr_q    <= '0;
      init_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      rr_ptr  <= rr_ptr_nxt;
      grant_q <= grant_nxt;
      wr_q    <= wr_nxt;
      init_q  <= init_nxt;
      drop_q  <= drop_nxt;
    end
  end

  assign rf_we     = wr_q.we;
  assign rf_waddr  = wr_q.waddr;
  assign rf_wdata  = wr_q.wdata;
  assign init_done = init_q;
  assign grant_id  = grant_q;
  assign x0_drop   = drop_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed requests, queued expected writes.
module tb_regfile_wr_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned XLEN = 32;
  localparam int unsigned IW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 rf_we;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 init_done;
  logic [IW-1:0]        grant_id;
  logic                 x0_drop;

  typedef struct {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            drop;
    logic [IW-1:0]   gid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .init_done (init_done),
    .grant_id  (grant_id),
    .x0_drop   (x0_drop)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every visible write or drop pulse consumes one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (rf_we || x0_drop)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got we=%0b drop=%0b addr=%0d data=%0h expected none (t=%0t)",
                   rf_we, x0_drop, rf_waddr, rf_wdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wr_we",   64'(rf_we),    64'(!e.drop));
          chk("wr_drop", 64'(x0_drop),  64'(e.drop));
          chk("wr_addr", 64'(rf_waddr), 64'(e.a));
          chk("wr_data", 64'(rf_wdata), 64'(e.d));
          chk("wr_gid",  64'(grant_id), 64'(e.gid));
        end
      end
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                          input logic drop, input int g);
    exp_t e;
    e.a = a; e.d = d; e.drop = drop; e.gid = IW'(g);
    exp_q.push_back(e);
  endtask

  // Drive one cycle of requests; exp_rdy/g are the hand-computed grant.
  task automatic issue(input logic [NREQ-1:0] v,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                       input logic [NREQ-1:0] exp_rdy, input int g);
    logic [AW-1:0]   aa [3];
    logic [XLEN-1:0] dd [3];
    aa[0] = a0; aa[1] = a1; aa[2] = a2;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    @(negedge clk);
    #1;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
    #3;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (exp_rdy != '0) push_exp(aa[g], dd[g], (aa[g] == '0), g);
  endtask

  task automatic idle();
    issue('0, '0, '0, '0, '0, '0, '0, '0, 0);
  endtask

  // Release reset (expects rst_n low) and follow the clear sweep; abort_at>0 re-asserts reset.
  task automatic run_clear(input int abort_at);
    @(negedge clk);
    #1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) push_exp(AW'(i), '0, 1'b0, 0);
    rst_n     = 1'b1;
    req_valid = '1;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'h33, 32'h22, 32'h11};
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        #1;
        chk("abort_queue", 64'(exp_q.size()), 64'(32 - abort_at));
        rst_n = 1'b0;
        #1;
        chk("abort_we",    64'(rf_we),     64'd0);
        chk("abort_init",  64'(init_done), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        return;
      end
      if (k <= 32) chk("clear_ready", 64'(req_ready), 64'd0);
      if (k == 32) begin
        chk("clear_last_addr", 64'(rf_waddr),  64'd31);
        chk("init_before",     64'(init_done), 64'd0);
        #1;
        req_valid = '0;
      end
      if (k == 33) begin
        chk("init_after",     64'(init_done), 64'd1);
        chk("we_after_clear", 64'(rf_we),     64'd0);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    #12;
    chk("rst_we",    64'(rf_we),     64'd0);
    chk("rst_waddr", 64'(rf_waddr),  64'd0);
    chk("rst_wdata", 64'(rf_wdata),  64'd0);
    chk("rst_init",  64'(init_done), 64'd0);
    chk("rst_gid",   64'(grant_id),  64'd0);
    chk("rst_drop",  64'(x0_drop),   64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);

    run_clear(0);

    // Single request from requester 0 (ptr 0 -> 1).
    issue(3'b001, 5'd5, '0, '0, 32'hDEADBEEF, '0, '0, 3'b001, 0);
    idle();

    // All valid from ptr 1: grants 1,2,0,1,2,0.
    issue(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 3'b010, 1);
    issue(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 3'b100, 2);
    issue(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 3'b001, 0);
    issue(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 3'b010, 1);
    issue(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 3'b100, 2);
    issue(3'b111, 5'd1, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'hA3, 3'b001, 0);

    // x0 target from requester 1 is dropped (ptr 1 -> 2).
    issue(3'b010, '0, 5'd0, '0, '0, 32'h1234, '0, 3'b010, 1);
    idle();

    // ptr 2, only requester 0: wraps, then granted every cycle.
    issue(3'b001, 5'd7, '0, '0, 32'h77, '0, '0, 3'b001, 0);
    issue(3'b001, 5'd7, '0, '0, 32'h78, '0, '0, 3'b001, 0);
    issue(3'b001, 5'd7, '0, '0, 32'h79, '0, '0, 3'b001, 0);
    issue(3'b001, 5'd7, '0, '0, 32'h7A, '0, '0, 3'b001, 0);
    idle();

    // Top address from requester 2 (ptr 1 -> 0), then requester 1 (ptr 0 -> 2).
    issue(3'b100, '0, '0, 5'd31, '0, '0, 32'hFFFFFFFF, 3'b100, 2);
    issue(3'b010, '0, 5'd9, '0, '0, 32'h55, '0, 3'b010, 1);

    // Reset with that write in flight.
    @(posedge clk);
    #1;
    chk("inflight_we",    64'(rf_we),        64'd1);
    chk("inflight_queue", 64'(exp_q.size()), 64'd1);
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("run_rst_we",   64'(rf_we),     64'd0);
    chk("run_rst_init", 64'(init_done), 64'd0);
    chk("run_rst_gid",  64'(grant_id),  64'd0);
    exp_q.delete();

    run_clear(10);
    run_clear(0);

    // ptr restarts at 0: requesters 1,2 valid -> 1 then 2.
    issue(3'b110, '0, 5'd6, 5'd8, '0, 32'h66, 32'h88, 3'b010, 1);
    issue(3'b110, '0, 5'd6, 5'd8, '0, 32'h66, 32'h88, 3'b100, 2);
    idle();
    idle();
    idle();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
